ucode_seq: RTL and testbench

UCODE_SEQ -- requirements
Module: ucode_seq

---
 rtl/ucode_pkg.sv | 96 +++++++++
 rtl/ucode_urom.sv | 28 ++
 rtl/ucode_seq.sv | 194 +++++++++++++++++++
 tb/tb_ucode_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared definitions for the micro-code sequencer: macro opcodes, ROM entry points,
// ROM entry layout, sequencer states and the micro-ROM image.
package ucode_pkg;

  localparam int TMPL_W = 32;

  localparam logic [6:0] OP_MUL_IMM  = 7'b0010000;
  localparam logic [6:0] OP_MULS_IMM = 7'b0011000;
  localparam logic [6:0] OP_MUL_REG  = 7'b0110000;
  localparam logic [6:0] OP_MULS_REG = 7'b0111000;

  localparam logic [6:0] U_ZERO  = 7'h01;
  localparam logic [6:0] U_ADD   = 7'h02;
  localparam logic [6:0] U_SUBI  = 7'h03;
  localparam logic [6:0] U_CMPI  = 7'h04;
  localparam logic [6:0] U_CMPSI = 7'h05;
  localparam logic [6:0] U_CMP   = 7'h06;
  localparam logic [6:0] U_CMPS  = 7'h07;
  localparam logic [6:0] U_BNE   = 7'h08;

  localparam logic [3:0]  R_T      = 4'd15;
  localparam logic [15:0] BR_BACK3 = 16'hFFFD;

  localparam int EP_MUL_IMM     = 0;
  localparam int EP_MULS_IMM    = 5;
  localparam int EP_MUL_REG     = 10;
  localparam int EP_MULS_REG    = 15;
  localparam int EP_ZS_MUL_IMM  = 20;
  localparam int EP_ZS_MULS_IMM = 21;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BR_WAIT = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [TMPL_W-1:0] tmpl;
    logic              sub_rd;
    logic              sub_rs1;
    logic              sub_rs2;
    logic              sub_imm;
    logic              is_branch;
    logic              last;
  } urom_entry_t;

  function automatic logic [TMPL_W-1:0] t_r(input logic [6:0] op, input logic [3:0] rd,
                                            input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 13'h0000};
  endfunction

  function automatic logic [TMPL_W-1:0] t_i(input logic [6:0] op, input logic [3:0] rd,
                                            input logic [3:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b0, imm};
  endfunction

  // ctl order: sub_rd, sub_rs1, sub_rs2, sub_imm, is_branch, last
  function automatic urom_entry_t mk(input logic [TMPL_W-1:0] tmpl, input logic [5:0] ctl);
    urom_entry_t e;
    e.tmpl = tmpl;
    {e.sub_rd, e.sub_rs1, e.sub_rs2, e.sub_imm, e.is_branch, e.last} = ctl;
    return e;
  endfunction

  function automatic urom_entry_t urom_image(input int unsigned idx);
    urom_entry_t e;
    e = '0;
    if (idx < 32'd20) begin
      case (idx % 32'd5)
        32'd0: e = mk(t_i(U_ZERO, 4'd0, 4'd0, 16'h0000), 6'b100000);
        32'd1: e = mk(t_r(U_ADD, 4'd0, 4'd0, 4'd0), 6'b110000);
        32'd2: e = mk(t_i(U_SUBI, R_T, R_T, 16'h0001), 6'b000000);
        32'd3: begin
          case (idx / 32'd5)
            32'd0:   e = mk(t_i(U_CMPI, 4'd0, R_T, 16'h0000), 6'b000100);
            32'd1:   e = mk(t_i(U_CMPSI, 4'd0, R_T, 16'h0000), 6'b000100);
            32'd2:   e = mk(t_r(U_CMP, 4'd0, R_T, 4'd0), 6'b001000);
            32'd3:   e = mk(t_r(U_CMPS, 4'd0, R_T, 4'd0), 6'b001000);
            default: e = '0;
          endcase
        end
        32'd4:   e = mk(t_i(U_BNE, 4'd0, 4'd0, BR_BACK3), 6'b000011);
        default: e = '0;
      endcase
    end else begin
      case (idx)
        32'd20:  e = mk(t_i(U_ZERO, 4'd0, 4'd0, 16'h0000), 6'b100001);
        32'd21:  e = mk(t_i(U_ZERO, 4'd0, 4'd0, 16'h0000), 6'b100000);
        32'd22:  e = mk(t_i(U_CMPSI, 4'd0, R_T, 16'h0000), 6'b000101);
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/ucode_urom.sv
// Registered-read micro-ROM: the entry at i_addr appears on o_entry after one clock.
module ucode_urom
  import ucode_pkg::*;
#(
  parameter int UROM_DEPTH = 32,
  parameter int UPC_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [UPC_W-1:0] i_addr,
  output urom_entry_t      o_entry
);

  urom_entry_t r_entry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry <= '0;
    end else if (32'(i_addr) < $unsigned(UROM_DEPTH)) begin
      r_entry <= urom_image(32'(i_addr));
    end else begin
      r_entry <= '0;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/ucode_seq.sv
// Micro-code sequencer: expands multiply macro-ops into micro-op streams from a micro-ROM.
// Optional build macro UCODE_SEQ_ZERO_SKIP_EN shortens immediate multiplies by zero.
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int UROM_DEPTH = 32,
  parameter int MAX_ITER   = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [6:0]      start_opcode,
  input  logic [15:0]     start_imm,
  input  logic [3:0]      start_rd,
  input  logic [3:0]      start_rs1,
  input  logic [3:0]      start_rs2,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic [XLEN-1:0] uop_instr,
  output logic            uop_last,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int UPC_W  = (UROM_DEPTH > 1) ? $clog2(UROM_DEPTH) : 1;
  localparam int ITER_W = $clog2(MAX_ITER + 1);
`ifdef UCODE_SEQ_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  seq_state_t         r_state, w_state_nxt;
  logic [UPC_W-1:0]   r_upc, w_upc_nxt, w_ep;
  logic [ITER_W-1:0]  r_iter, w_iter_nxt;
  logic [3:0]         r_rd, r_rs1, r_rs2;
  logic [15:0]        r_imm;
  logic               r_done, r_err, w_done_nxt, w_err_nxt, w_accept, w_op_ok;
  urom_entry_t        w_entry;
  logic [UPC_W:0]     w_seq_upc;
  logic               w_seq_wrap, w_br_bad, w_iter_max;
  logic signed [17:0] w_br_tgt;
  logic [TMPL_W-1:0]  w_instr;

  ucode_urom #(.UROM_DEPTH(UROM_DEPTH), .UPC_W(UPC_W)) u_urom (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_addr  (w_upc_nxt),
    .o_entry (w_entry)
  );

  // Opcode decode to ROM entry point
  always_comb begin
    w_op_ok = 1'b1;
    case (start_opcode)
      OP_MUL_IMM:  w_ep = (ZERO_SKIP && start_imm == 16'h0000) ? UPC_W'(EP_ZS_MUL_IMM)
                                                               : UPC_W'(EP_MUL_IMM);
      OP_MULS_IMM: w_ep = (ZERO_SKIP && start_imm == 16'h0000) ? UPC_W'(EP_ZS_MULS_IMM)
                                                               : UPC_W'(EP_MULS_IMM);
      OP_MUL_REG:  w_ep = UPC_W'(EP_MUL_REG);
      OP_MULS_REG: w_ep = UPC_W'(EP_MULS_REG);
      default: begin
        w_ep    = '0;
        w_op_ok = 1'b0;
      end
    endcase
  end

  assign w_seq_upc  = {1'b0, r_upc} + {{UPC_W{1'b0}}, 1'b1};
  assign w_seq_wrap = (w_seq_upc >= (UPC_W+1)'(UROM_DEPTH));
  assign w_br_tgt   = $signed(18'(r_upc)) + $signed({{2{w_entry.tmpl[15]}}, w_entry.tmpl[15:0]});
  assign w_br_bad   = w_br_tgt[17] || (w_br_tgt[16:0] >= 17'(UROM_DEPTH));
  assign w_iter_max = (r_iter == ITER_W'(MAX_ITER));

  // Next-state, next-uPC and status pulse logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_upc_nxt   = r_upc;
    w_iter_nxt  = r_iter;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_accept    = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            w_accept = 1'b1;
            if (w_op_ok) begin
              w_state_nxt = S_ISSUE;
              w_upc_nxt   = w_ep;
              w_iter_nxt  = '0;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_accept = 1'b0;
          end
        end
        S_ISSUE: begin
          if (!uop_ready) begin
            w_state_nxt = S_ISSUE;
          end else if (w_entry.is_branch) begin
            w_state_nxt = S_BR_WAIT;
          end else if (w_entry.last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_seq_wrap) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end else begin
            w_upc_nxt = w_seq_upc[UPC_W-1:0];
          end
        end
        S_BR_WAIT: begin
          if (!br_valid) begin
            w_state_nxt = S_BR_WAIT;
          end else if (br_taken) begin
            if (w_iter_max || w_br_bad) begin
              w_state_nxt = S_IDLE;
              w_err_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_ISSUE;
              w_upc_nxt   = w_br_tgt[UPC_W-1:0];
              w_iter_nxt  = r_iter + ITER_W'(1);
            end
          end else if (w_entry.last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_seq_wrap) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
            w_upc_nxt   = w_seq_upc[UPC_W-1:0];
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, uPC, iteration count, status pulses and operand latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_upc   <= '0;
      r_iter  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_upc   <= w_upc_nxt;
      r_iter  <= w_iter_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_rd  <= start_rd;
        r_rs1 <= start_rs1;
        r_rs2 <= start_rs2;
        r_imm <= start_imm;
      end
    end
  end

  // Operand substitution into the ROM template; imm is applied after rs2 as they overlap
  always_comb begin
    w_instr        = w_entry.tmpl;
    w_instr[24:21] = w_entry.sub_rd  ? r_rd  : w_entry.tmpl[24:21];
    w_instr[20:17] = w_entry.sub_rs1 ? r_rs1 : w_entry.tmpl[20:17];
    w_instr[16:13] = w_entry.sub_rs2 ? r_rs2 : w_entry.tmpl[16:13];
    w_instr[15:0]  = w_entry.sub_imm ? r_imm : w_instr[15:0];
  end

  assign uop_instr   = XLEN'(w_instr);
  assign uop_last    = w_entry.last;
  assign uop_valid   = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE);
  assign start_ready = (r_state == S_IDLE) && !flush && rst;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_ucode_seq.sv
// Directed self-checking bench for ucode_seq (default build plus a MAX_ITER=2 instance).
module tb_ucode_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid, start_valid2;
  logic [6:0]  start_opcode;
  logic [15:0] start_imm;
  logic [3:0]  start_rd, start_rs1, start_rs2;
  logic        uop_ready, br_valid, br_taken, flush;

  logic        start_ready, uop_valid, uop_last, busy, done, err;
  logic [31:0] uop_instr;
  logic        start_ready2, uop_valid2, uop_last2, busy2, done2, err2;
  logic [31:0] uop_instr2;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int saved_done;

  always #5 clk = ~clk;

  ucode_seq u_dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .start_opcode(start_opcode), .start_imm(start_imm), .start_rd(start_rd),
    .start_rs1(start_rs1), .start_rs2(start_rs2), .uop_valid(uop_valid),
    .uop_ready(uop_ready), .uop_instr(uop_instr), .uop_last(uop_last),
    .br_valid(br_valid), .br_taken(br_taken), .flush(flush), .busy(busy),
    .done(done), .err(err)
  );

  ucode_seq #(.MAX_ITER(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_valid(start_valid2), .start_ready(start_ready2),
    .start_opcode(start_opcode), .start_imm(start_imm), .start_rd(start_rd),
    .start_rs1(start_rs1), .start_rs2(start_rs2), .uop_valid(uop_valid2),
    .uop_ready(uop_ready), .uop_instr(uop_instr2), .uop_last(uop_last2),
    .br_valid(br_valid), .br_taken(br_taken), .flush(flush), .busy(busy2),
    .done(done2), .err(err2)
  );

  always @(negedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Check the micro-op currently offered (uop_ready assumed high) and advance one cycle
  task automatic issue(input string tag, input logic [31:0] exp_instr, input logic exp_last);
    chk1({tag, "_valid"}, uop_valid, 1'b1);
    chk32({tag, "_instr"}, uop_instr, exp_instr);
    chk1({tag, "_last"}, uop_last, exp_last);
    step();
  endtask

  task automatic start(input logic [6:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [15:0] imm);
    start_opcode = op; start_rd = rd; start_rs1 = rs1; start_rs2 = rs2; start_imm = imm;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_valid = 1'b0; start_valid2 = 1'b0; start_opcode = 7'd0;
    start_imm = 16'd0; start_rd = 4'd0; start_rs1 = 4'd0; start_rs2 = 4'd0;
    uop_ready = 1'b1; br_valid = 1'b0; br_taken = 1'b0; flush = 1'b0;
    #2;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_uop_valid", uop_valid, 1'b0);
    chk32("rst_uop_instr", uop_instr, 32'h0000_0000);
    chk1("rst_uop_last", uop_last, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_start_ready", start_ready, 1'b0);
    step(); step();
    rst = 1'b1;
    #1 chk1("idle_start_ready", start_ready, 1'b1);

    // MUL_IMM rd=3 rs1=2 imm=3, branch taken twice then not taken
    start(7'b0010000, 4'd3, 4'd2, 4'd0, 16'd3);
    chk1("m1_busy", busy, 1'b1);
    chk1("m1_start_ready", start_ready, 1'b0);
    issue("m1_zero", 32'h0260_0000, 1'b0);
    for (int it = 0; it < 3; it++) begin
      issue("m1_add", 32'h0464_0000, 1'b0);
      issue("m1_sub", 32'h07FE_0001, 1'b0);
      issue("m1_cmp", 32'h081E_0003, 1'b0);
      issue("m1_bne", 32'h1000_FFFD, 1'b1);
      chk1("m1_brwait_valid", uop_valid, 1'b0);
      chk1("m1_brwait_busy", busy, 1'b1);
      br_valid = 1'b1; br_taken = (it < 2);
      step();
      br_valid = 1'b0; br_taken = 1'b0;
    end
    chk1("m1_done", done, 1'b1);
    chk1("m1_idle_busy", busy, 1'b0);
    chk1("m1_ready_after", start_ready, 1'b1);
    chk1("m1_idle_valid", uop_valid, 1'b0);
    step();
    chk1("m1_done_pulse", done, 1'b0);
    chk32("m1_done_cnt", 32'(done_cnt), 32'd1);

    // MUL_REG with 4 cycles of backpressure on the add
    start(7'b0110000, 4'd5, 4'd6, 4'd7, 16'h1234);
    issue("m2_zero", 32'h02A0_0000, 1'b0);
    uop_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("m2_stall_valid", uop_valid, 1'b1);
      chk32("m2_stall_instr", uop_instr, 32'h04AC_0000);
      chk1("m2_stall_last", uop_last, 1'b0);
      step();
    end
    uop_ready = 1'b1;
    issue("m2_add", 32'h04AC_0000, 1'b0);
    issue("m2_sub", 32'h07FE_0001, 1'b0);
    issue("m2_cmp", 32'h0C1E_E000, 1'b0);
    issue("m2_bne", 32'h1000_FFFD, 1'b1);
    br_valid = 1'b1; br_taken = 1'b0;
    step();
    br_valid = 1'b0;
    chk1("m2_done", done, 1'b1);
    chk1("m2_busy", busy, 1'b0);

    // Illegal opcode
    step();
    start(7'b1111111, 4'd1, 4'd1, 4'd1, 16'd1);
    chk1("ill_err", err, 1'b1);
    chk1("ill_valid", uop_valid, 1'b0);
    chk1("ill_busy", busy, 1'b0);
    chk1("ill_done", done, 1'b0);
    step();
    chk1("ill_err_pulse", err, 1'b0);
    chk1("ill_busy2", busy, 1'b0);

    // MULS_IMM, flush in BR_WAIT together with br_valid
    start(7'b0011000, 4'd1, 4'd4, 4'd0, 16'd2);
    issue("m3_zero", 32'h0220_0000, 1'b0);
    issue("m3_add", 32'h0428_0000, 1'b0);
    issue("m3_sub", 32'h07FE_0001, 1'b0);
    issue("m3_cmps", 32'h0A1E_0002, 1'b0);
    issue("m3_bne", 32'h1000_FFFD, 1'b1);
    br_valid = 1'b1; br_taken = 1'b1; flush = 1'b1;
    step();
    br_valid = 1'b0; br_taken = 1'b0; flush = 1'b0;
    #1;
    chk1("fl_busy", busy, 1'b0);
    chk1("fl_valid", uop_valid, 1'b0);
    chk1("fl_done", done, 1'b0);
    chk1("fl_err", err, 1'b0);
    chk1("fl_ready", start_ready, 1'b1);
    start(7'b0010000, 4'd3, 4'd2, 4'd0, 16'd3);
    chk1("fl_restart_valid", uop_valid, 1'b1);
    chk32("fl_restart_instr", uop_instr, 32'h0260_0000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("fl_issue_valid", uop_valid, 1'b0);
    chk1("fl_issue_busy", busy, 1'b0);
    chk1("fl_issue_done", done, 1'b0);
    flush = 1'b1; start_valid = 1'b1;
    #1 chk1("fl_blocks_ready", start_ready, 1'b0);
    step();
    start_valid = 1'b0; flush = 1'b0;
    chk1("fl_blocks_start", busy, 1'b0);
    chk32("fl_done_cnt", 32'(done_cnt), 32'd2);

    // MULS_IMM with imm=0
    start(7'b0011000, 4'd2, 4'd4, 4'd0, 16'd0);
    issue("z_zero", 32'h0240_0000, 1'b0);
`ifdef UCODE_SEQ_ZERO_SKIP_EN
    issue("z_cmps", 32'h0A1E_0000, 1'b1);
`else
    issue("z_add", 32'h0448_0000, 1'b0);
    issue("z_sub", 32'h07FE_0001, 1'b0);
    issue("z_cmps", 32'h0A1E_0000, 1'b0);
    issue("z_bne", 32'h1000_FFFD, 1'b1);
    br_valid = 1'b1; br_taken = 1'b0;
    step();
    br_valid = 1'b0;
`endif
    chk1("z_done", done, 1'b1);
    chk1("z_busy", busy, 1'b0);

    // Reset in the middle of a macro-op
    step();
    start(7'b0110000, 4'd5, 4'd6, 4'd7, 16'd0);
    issue("r_zero", 32'h02A0_0000, 1'b0);
    saved_done = done_cnt;
    #2 rst = 1'b0;
    #1;
    chk1("r_busy", busy, 1'b0);
    chk1("r_valid", uop_valid, 1'b0);
    chk32("r_instr", uop_instr, 32'h0000_0000);
    chk1("r_last", uop_last, 1'b0);
    chk1("r_ready", start_ready, 1'b0);
    step();
    rst = 1'b1;
    br_valid = 1'b1; br_taken = 1'b0;
    step(); step();
    br_valid = 1'b0;
    step();
    chk1("r_after_busy", busy, 1'b0);
    chk32("r_no_done", 32'(done_cnt), 32'(saved_done));

    // MAX_ITER=2 instance, branch always taken: err on the third taken branch
    start_opcode = 7'b0010000; start_rd = 4'd3; start_rs1 = 4'd2; start_imm = 16'd3;
    start_valid2 = 1'b1;
    step();
    start_valid2 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < ((r == 0) ? 5 : 4); k++) begin
        chk1("mi_valid", uop_valid2, 1'b1);
        step();
      end
      chk1("mi_brwait_valid", uop_valid2, 1'b0);
      br_valid = 1'b1; br_taken = 1'b1;
      step();
      br_valid = 1'b0; br_taken = 1'b0;
      if (r < 2) begin
        chk1("mi_loop_valid", uop_valid2, 1'b1);
        chk1("mi_loop_err", err2, 1'b0);
      end else begin
        chk1("mi_err", err2, 1'b1);
        chk1("mi_busy", busy2, 1'b0);
        chk1("mi_valid_off", uop_valid2, 1'b0);
      end
    end
    chk1("mi_other_idle", busy, 1'b0);
    step();
    chk1("mi_err_pulse", err2, 1'b0);
    chk32("mi_no_done", 32'(done2_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
